// File: rtl/farm_sensor_if.sv
// Farm-road vehicle loop conditioner and farmSensor request generator for the TLC.
// Synchronises and debounces the loop, latches a service request until the farm road goes GREEN.
module farm_sensor_if #(
    parameter int unsigned DEB_CYC   = 4,
    parameter int unsigned STUCK_CYC = 240,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             loop_raw,
    input  logic [1:0]       f_s,
    output logic             farmSensor,
    output logic             stuck_fault,
    output logic [CNT_W-1:0] veh_count,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQUEST = 3'd1,
        ST_SERVED  = 3'd2,
        ST_FAULT   = 3'd3
    } state_e;

    localparam logic [1:0] LAMP_YELLOW = 2'b01;
    localparam logic [1:0] LAMP_GREEN  = 2'b10;
    localparam logic [5:0] DEB_LAST    = 6'(DEB_CYC - 1);
    localparam logic [9:0] HI_MAX      = 10'(STUCK_CYC);

    logic             s1_q, s2_q;
    logic             deb_q, deb_d;
    logic             deb_dly_q;
    logic [5:0]       stab_cnt_q, stab_cnt_d;
    logic [9:0]       hi_cnt_q, hi_cnt_d;
    logic [CNT_W-1:0] veh_count_q, veh_count_d;
    state_e           state_q, state_d;
    logic             farm_sensor_q, farm_sensor_d;
    logic             stuck_fault_q, stuck_fault_d;
    logic             lamp_green, lamp_red, loop_stuck;

    // Two-flop synchroniser for the asynchronous loop input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= loop_raw;
            s2_q <= s1_q;
        end
    end

    // Debounce: deb flips only after DEB_CYC consecutive disagreeing samples.
    always_comb begin
        stab_cnt_d = '0;
        deb_d      = deb_q;
        if (s2_q != deb_q) begin
            if (stab_cnt_q == DEB_LAST) begin
                deb_d      = ~deb_q;
                stab_cnt_d = '0;
            end else begin
                stab_cnt_d = stab_cnt_q + 6'd1;
            end
        end
    end

    always_comb begin
        hi_cnt_d = '0;
        if (deb_q) begin
            hi_cnt_d = (hi_cnt_q == HI_MAX) ? HI_MAX : hi_cnt_q + 10'd1;
        end
    end

    // A vehicle is counted one edge after its debounced arrival.
    always_comb begin
        veh_count_d = veh_count_q;
        if (deb_q && !deb_dly_q) begin
            veh_count_d = veh_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_q       <= 1'b0;
            deb_dly_q   <= 1'b0;
            stab_cnt_q  <= '0;
            hi_cnt_q    <= '0;
            veh_count_q <= '0;
        end else begin
            deb_q       <= deb_d;
            deb_dly_q   <= deb_q;
            stab_cnt_q  <= stab_cnt_d;
            hi_cnt_q    <= hi_cnt_d;
            veh_count_q <= veh_count_d;
        end
    end

    assign lamp_green = (f_s == LAMP_GREEN);
    assign lamp_red   = (f_s != LAMP_GREEN) && (f_s != LAMP_YELLOW);
    assign loop_stuck = (hi_cnt_q == HI_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A stuck loop outranks every other transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (loop_stuck)  state_d = ST_FAULT;
                else if (deb_q)  state_d = ST_REQUEST;
            end
            ST_REQUEST: begin
                if (loop_stuck)      state_d = ST_FAULT;
                else if (lamp_green) state_d = ST_SERVED;
            end
            ST_SERVED: begin
                if (loop_stuck)            state_d = ST_FAULT;
                else if (lamp_red && deb_q) state_d = ST_REQUEST;
                else if (lamp_red)          state_d = ST_IDLE;
            end
            ST_FAULT: begin
                if (!deb_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        farm_sensor_d = (state_d == ST_REQUEST);
        stuck_fault_d = (state_d == ST_FAULT);
    end

    // Outputs come straight from flops so the TLC sees glitch-free levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            farm_sensor_q <= 1'b0;
            stuck_fault_q <= 1'b0;
        end else begin
            farm_sensor_q <= farm_sensor_d;
            stuck_fault_q <= stuck_fault_d;
        end
    end

    assign farmSensor  = farm_sensor_q;
    assign stuck_fault = stuck_fault_q;
    assign veh_count   = veh_count_q;
    assign state       = state_q;

endmodule

// File: tb/tb_farm_sensor_if.sv
// Bench for farm_sensor_if: directed scenarios plus randomized loop/TLC traffic,
// checked every cycle against a behavioural model of the request rules.
module tb_farm_sensor_if;

    localparam int DEB   = 4;
    localparam int STUCK = 20;
    localparam int CW    = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          loop_raw = 1'b0;
    logic [1:0]    f_s = 2'b00;
    logic          farmSensor;
    logic          stuck_fault;
    logic [CW-1:0] veh_count;
    logic [2:0]    state;

    int n_checks = 0;
    int n_errors = 0;
    int exp_cnt  = 0;

    farm_sensor_if #(
        .DEB_CYC  (DEB),
        .STUCK_CYC(STUCK),
        .CNT_W    (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .loop_raw   (loop_raw),
        .f_s        (f_s),
        .farmSensor (farmSensor),
        .stuck_fault(stuck_fault),
        .veh_count  (veh_count),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Behavioural reference: loop history window, run length of presence, lamp rules.
    bit m_pipe [2];
    bit m_hist [$];
    bit m_deb, m_new_arrival;
    int m_hi_run, m_state, m_cnt;

    always @(posedge clk) begin
        bit s2_now, all_diff, nd, stuck, green, red;
        int ns;
        if (!rst_n) begin
            m_pipe[0] = 0; m_pipe[1] = 0;
            m_hist.delete();
            m_deb = 0; m_new_arrival = 0;
            m_hi_run = 0; m_state = 0; m_cnt = 0;
        end else begin
            s2_now = m_pipe[1];
            m_hist.push_back(s2_now);
            if (m_hist.size() > DEB) void'(m_hist.pop_front());
            all_diff = (m_hist.size() == DEB);
            foreach (m_hist[k]) if (m_hist[k] == m_deb) all_diff = 0;
            nd = all_diff ? !m_deb : m_deb;
            stuck = (m_hi_run >= STUCK);
            green = (f_s == 2'b10);
            red   = (f_s == 2'b00) || (f_s == 2'b11);
            case (m_state)
                0: ns = stuck ? 3 : (m_deb ? 1 : 0);
                1: ns = stuck ? 3 : (green ? 2 : 1);
                2: ns = stuck ? 3 : (red ? (m_deb ? 1 : 0) : 2);
                default: ns = m_deb ? 3 : 0;
            endcase
            if (m_new_arrival) m_cnt = (m_cnt + 1) % (1 << CW);
            m_new_arrival = nd && !m_deb;
            m_hi_run = m_deb ? m_hi_run + 1 : 0;
            m_state = ns;
            m_deb = nd;
            m_pipe[1] = m_pipe[0];
            m_pipe[0] = loop_raw;
        end
        #1;
        check_val("mdl_farmSensor", farmSensor, (m_state == 1));
        check_val("mdl_stuck", stuck_fault, (m_state == 3));
        check_val("mdl_veh_count", veh_count, m_cnt);
        check_val("mdl_state", state, m_state);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic serve();
        f_s = 2'b10;
        repeat (3) tick();
        f_s = 2'b01;
        repeat (2) tick();
        f_s = 2'b00;
        repeat (2) tick();
    endtask

    // Runs a small TLC: grants GREEN a couple of cycles after the request, then YELLOW, then RED.
    task automatic tlc_run(input int ncyc, input bit rnd, input int pulse_len, input int green_len,
                           output int greens);
        int ph, t, red_wait, raw_left, gap_left;
        ph = 0; t = 0; red_wait = 0; greens = 0;
        raw_left = pulse_len; gap_left = 0;
        for (int c = 0; c < ncyc; c++) begin
            if (raw_left > 0) begin
                loop_raw = 1'b1;
                raw_left--;
            end else begin
                loop_raw = 1'b0;
                if (rnd) begin
                    if (gap_left > 0) gap_left--;
                    else begin
                        raw_left = $urandom_range(1, 14);
                        gap_left = $urandom_range(2, 20);
                    end
                end
            end
            case (ph)
                0: begin
                    if (farmSensor) red_wait++;
                    if (red_wait >= 2) begin
                        ph = 1; f_s = 2'b10; greens++;
                        t = rnd ? $urandom_range(2, 8) : green_len;
                    end
                end
                1: begin
                    t--;
                    if (t <= 0) begin ph = 2; f_s = 2'b01; t = 2; end
                end
                default: begin
                    t--;
                    if (t <= 0) begin
                        ph = 0; red_wait = 0;
                        f_s = (rnd && ($urandom_range(0, 3) == 0)) ? 2'b11 : 2'b00;
                    end
                end
            endcase
            tick();
        end
        f_s = 2'b00;
        loop_raw = 1'b0;
    endtask

    initial begin
        int k, hi_samples, greens;

        // 1: reset holds everything low even with a car on the loop; request on edge 7 after release.
        rst_n = 1'b0; loop_raw = 1'b1; f_s = 2'b00;
        repeat (5) tick();
        check_val("t1_rst_farmSensor", farmSensor, 0);
        check_val("t1_rst_stuck", stuck_fault, 0);
        check_val("t1_rst_veh", veh_count, 0);
        check_val("t1_rst_state", state, 0);
        rst_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (e == 6) check_val("t1_edge6_farmSensor", farmSensor, 0);
            if (e == 7) check_val("t1_edge7_farmSensor", farmSensor, 1);
        end
        exp_cnt = 1;
        loop_raw = 1'b0;
        repeat (8) tick();
        serve();
        check_val("t1_served_state", state, 0);
        $display("INFO t1 reset/latency done, veh_count=%0d", veh_count);

        // 2: a 3-cycle glitch is rejected, a 4-cycle pulse is a vehicle.
        loop_raw = 1'b1; repeat (3) tick(); loop_raw = 1'b0;
        repeat (10) tick();
        check_val("t2_glitch_veh", veh_count, exp_cnt);
        check_val("t2_glitch_farmSensor", farmSensor, 0);
        loop_raw = 1'b1; repeat (4) tick(); loop_raw = 1'b0;
        repeat (8) tick();
        exp_cnt++;
        check_val("t2_pulse_veh", veh_count, exp_cnt);
        check_val("t2_pulse_farmSensor", farmSensor, 1);
        serve();
        check_val("t2_served_state", state, 0);
        $display("INFO t2 glitch reject done, veh_count=%0d", veh_count);

        // 3: request stays latched after the car leaves, until GREEN.
        loop_raw = 1'b1; repeat (5) tick(); loop_raw = 1'b0;
        exp_cnt++;
        repeat (15) tick();
        check_val("t3_mid_farmSensor", farmSensor, 1);
        repeat (15) tick();
        check_val("t3_end_farmSensor", farmSensor, 1);
        f_s = 2'b10; tick();
        check_val("t3_green_farmSensor", farmSensor, 0);
        check_val("t3_green_state", state, 2);
        f_s = 2'b00; tick();
        check_val("t3_red_state", state, 0);
        check_val("t3_veh", veh_count, exp_cnt);
        $display("INFO t3 latched request done, veh_count=%0d", veh_count);

        // 4: queued car re-requests straight from SERVED on the RED edge.
        loop_raw = 1'b1; repeat (7) tick();
        exp_cnt++;
        check_val("t4_req_farmSensor", farmSensor, 1);
        f_s = 2'b10; tick();
        check_val("t4_green_state", state, 2);
        tick();
        f_s = 2'b01; repeat (2) tick();
        check_val("t4_yellow_state", state, 2);
        f_s = 2'b00; tick();
        check_val("t4_red_state", state, 1);
        check_val("t4_red_farmSensor", farmSensor, 1);
        check_val("t4_veh", veh_count, exp_cnt);
        loop_raw = 1'b0; repeat (8) tick();
        serve();
        check_val("t4_served_state", state, 0);
        repeat (4) tick();
        $display("INFO t4 queued car done, veh_count=%0d", veh_count);

        // 5: stuck loop: exactly STUCK cycles of request, then FAULT; clears 7 edges after release.
        loop_raw = 1'b1; hi_samples = 0;
        repeat (40) begin
            tick();
            if (farmSensor) hi_samples++;
        end
        exp_cnt++;
        check_val("t5_request_cycles", hi_samples, STUCK);
        check_val("t5_stuck", stuck_fault, 1);
        check_val("t5_farmSensor", farmSensor, 0);
        check_val("t5_veh", veh_count, exp_cnt);
        loop_raw = 1'b0; k = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (k == 0 && stuck_fault == 1'b0) k = i;
        end
        check_val("t5_release_edges", k, 7);
        check_val("t5_release_state", state, 0);
        $display("INFO t5 stuck loop done, veh_count=%0d", veh_count);

        // 6: closed loop with a TLC: one pulse gives one GREEN phase and one vehicle.
        rst_n = 1'b0; repeat (20) tick(); rst_n = 1'b1;
        exp_cnt = 0;
        tlc_run(60, 1'b0, 12, 10, greens);
        exp_cnt++;
        check_val("t6_green_phases", greens, 1);
        check_val("t6_veh", veh_count, exp_cnt);
        check_val("t6_final_state", state, 0);
        $display("INFO t6 closed loop done, greens=%0d", greens);

        // Randomized traffic, then a reset while a request is pending.
        tlc_run(500, 1'b1, 0, 0, greens);
        $display("INFO random traffic done, greens=%0d veh_count=%0d", greens, veh_count);
        repeat (30) tick();
        loop_raw = 1'b1; repeat (7) tick();
        check_val("rst_mid_pre", farmSensor, 1);
        rst_n = 1'b0;
        #1;
        check_val("rst_mid_drop", farmSensor, 0);
        check_val("rst_mid_veh", veh_count, 0);
        repeat (3) tick();
        rst_n = 1'b1; loop_raw = 1'b0;
        repeat (12) tick();
        check_val("rst_mid_no_memory", state, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
